// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in over a fixed gate of GATE_CYCLES clk cycles
//   clk      : system clock (27 MHz)
//   rst_n    : asynchronous active-low reset
//   en       : measurement enable, synchronous to clk
//   sig_in   : signal under measurement, asynchronous to clk
//   freq_hz  : rising-edge count of the last completed window (saturating)
//   valid    : one-cycle pulse when freq_hz is updated
//   overflow : the last completed window saturated the edge counter
module freq_meter #(
    parameter int GATE_CYCLES = 27_000_000,
    parameter int CNT_W       = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_hz,
    output logic             valid,
    output logic             overflow
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX = '1;

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state;
    logic             s1, s2, s3, edge_det, sat;
    logic [GW-1:0]    gate_cnt, gate_nxt;
    logic [CNT_W-1:0] edge_cnt, cnt_nxt;
    logic             sat_nxt, close;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            edge_det <= 1'b0;
        end else begin
            s1       <= sig_in;
            s2       <= s1;
            s3       <= s2;
            edge_det <= s2 & ~s3;
        end
    end

    // cnt_nxt/sat_nxt include this cycle's edge, so the close cycle can publish it
    always_comb begin
        close    = gate_cnt == LAST;
        gate_nxt = close ? '0 : gate_cnt + 1'b1;
        cnt_nxt  = (edge_det && edge_cnt != MAX) ? edge_cnt + 1'b1 : edge_cnt;
        sat_nxt  = sat | (edge_det && edge_cnt >= MAX - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            freq_hz  <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE:    state <= en ? COUNT : IDLE;
                COUNT:   state <= en ? COUNT : IDLE;
                default: state <= IDLE;
            endcase
            if (en) begin
                gate_cnt <= gate_nxt;
                edge_cnt <= close ? '0 : cnt_nxt;
                sat      <= ~close & sat_nxt;
                if (close) begin
                    valid    <= 1'b1;
                    freq_hz  <= cnt_nxt;
                    overflow <= sat_nxt;
                end
            end else begin
                // dropping en discards the partial window
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter (16-bit and 6-bit counter instances)
module tb_freq_meter;
    localparam int G = 1000;

    typedef struct {
        int f16;
        int o16;
        int f6;
        int o6;
        int at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, en, sig_in;
    logic [15:0] freq16;
    logic [5:0]  freq6;
    logic        valid16, valid6, ovf16, ovf6;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   per = 10;
    int   t_ref = 0;
    int   c_en = 0;
    exp_t q[$];

    freq_meter #(.GATE_CYCLES(G), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .freq_hz(freq16), .valid(valid16), .overflow(ovf16)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .freq_hz(freq6), .valid(valid6), .overflow(ovf6)
    );

    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // square wave with period per (0 = sig_in driven directly by the main sequence)
    initial begin
        int ph = 0;
        forever begin
            @(negedge clk);
            if (per != 0) begin
                ph = (ph + 1) % per;
                sig_in = ph < per / 2;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (valid16 || valid6) begin
            if (q.size() == 0) chk("spurious_valid", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("valid_match", int'(valid6), int'(valid16));
                chk("valid_time", cyc, e.at);
                chk("freq16", int'(freq16), e.f16);
                chk("ovf16", int'(ovf16), e.o16);
                chk("freq6", int'(freq6), e.f6);
                chk("ovf6", int'(ovf6), e.o6);
            end
        end
    end

    task automatic push(input int n, input int k);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            t_ref += G;
            e.f16 = n > 65535 ? 65535 : n;
            e.o16 = int'(n >= 65535);
            e.f6  = n > 63 ? 63 : n;
            e.o6  = int'(n >= 63);
            e.at  = t_ref;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        while (q.size() != 0 && cyc <= t_ref + 3) @(negedge clk);
        if (q.size() != 0) begin
            chk("valid_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_freq16", int'(freq16), 0);
        chk("rst_valid", int'(valid16), 0);
        chk("rst_ovf16", int'(ovf16), 0);
        chk("rst_ovf6", int'(ovf6), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // period 10 for three back-to-back windows
        en = 1'b1;
        t_ref = cyc;
        push(100, 3);
        drain();

        // en dropped mid-window: partial discarded, outputs held
        wait_to(t_ref + 500);
        en = 1'b0;
        wait_to(t_ref + 800);
        chk("hold_freq16", int'(freq16), 100);
        chk("hold_ovf6", int'(ovf6), 1);
        en = 1'b1;
        t_ref = cyc;
        push(100, 1);
        drain();

        // async reset mid-window
        wait_to(t_ref + 700);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("arst_freq16", int'(freq16), 0);
        chk("arst_freq6", int'(freq6), 0);
        chk("arst_ovf6", int'(ovf6), 0);
        chk("arst_valid", int'(valid16), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b1;
        t_ref = cyc;
        push(100, 1);
        wait_to(t_ref - G + 500);
        chk("restart_freq16", int'(freq16), 0);
        drain();

        // period 40: 6-bit instance leaves saturation
        en = 1'b0;
        per = 40;
        repeat (100) @(negedge clk);
        en = 1'b1;
        t_ref = cyc;
        push(25, 1);
        drain();

        // sig_in held low
        en = 1'b0;
        per = 0;
        sig_in = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        t_ref = cyc;
        push(0, 2);
        drain();

        // single rise whose edge_det lands exactly in the close cycle
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        t_ref = cyc;
        c_en = cyc;
        push(1, 1);
        push(0, 1);
        wait_to(c_en + G - 4);
        sig_in = 1'b1;
        drain();

        en = 1'b0;
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the frequency of an external digital signal with a fixed gate window derived from the 27 MHz system clock. It is the measurement counterpart to the frequency divider. Uses include closing the loop on generated display and BJT drive signals, and reading an external square wave for display. Each completed window publishes a rising-edge count; with the default 1 s gate, that count is the frequency in Hz.

## Interface

Parameters:

- `GATE_CYCLES`, default 27_000_000: length of one gate window in `clk` cycles (1 s at 27 MHz).
- `CNT_W`, default 25: width of the edge counter and `freq_hz`. It must hold the largest expected count.

Ports:

- `clk` input 1: system clock, 27 MHz.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: measurement enable, synchronous to `clk`.
- `sig_in` input 1: signal under measurement, asynchronous to `clk`.
- `freq_hz` output `CNT_W`: rising-edge count of the last completed window.
- `valid` output 1: one-cycle pulse when `freq_hz` is updated.
- `overflow` output 1: the last completed window saturated the edge counter.

## Operation

- **Synchronizer:** `sig_in` passes through two flops (`s1`, `s2`), then a third flop `s3`. A rising edge `edge_det = s2 & ~s3` is registered.
- **Gate counter:** `gate_cnt` counts 0 .. `GATE_CYCLES`-1, then wraps to 0. The cycle with `gate_cnt == GATE_CYCLES-1` is the close cycle.
- **Edge counter:** `edge_cnt` increments on each `edge_det` cycle while `en` = 1.
  - It saturates at 2^`CNT_W`-1 and does not wrap.
  - An edge that arrives while the counter is already saturated sets an internal `sat` flag.
  - Reaching the maximum value also sets `sat`.
- **Close cycle:**
  - `freq_hz` loads `edge_cnt` plus `edge_det` of this same cycle, saturated. The edge in the close cycle belongs to the closing window.
  - `overflow` loads `sat`, or `sat` as updated by this cycle's edge.
  - `valid` = 1 for exactly this one cycle.
  - `edge_cnt` is cleared to 0 and `sat` is cleared to 0. Counting restarts with the next cycle.
- **FSM states:**
  - IDLE, entered when `en` = 0: `gate_cnt`, `edge_cnt` and `sat` are held at 0. `freq_hz` and `overflow` retain their last values, and `valid` = 0.
  - COUNT, entered while `en` = 1: normal windows run back-to-back with no dead cycles.
- **Transitions:**
  - IDLE → COUNT on `en` = 1. The first window starts on that cycle, with `gate_cnt` = 0.
  - COUNT → IDLE on `en` = 0. The partial window is discarded, with no `valid` and no update.
- **Input constraint:** `sig_in` high and low phases must each be at least 2 `clk` periods, which keeps the input below 6.75 MHz. Faster inputs can under-count; this is not flagged.

## Timing

- **Reset values:** `freq_hz` = 0, `valid` = 0, `overflow` = 0. Internally, `gate_cnt`, `edge_cnt`, `sat`, `s1`, `s2` and `s3` are all 0, and the FSM is in IDLE.
- **Reset mid-window:** all state clears immediately. After `rst_n` deasserts, the next window starts fresh with `gate_cnt` = 0 on the first clock where `en` = 1.
- **Edge latency:** a `sig_in` rise is counted 3 `clk` rising edges after it is sampled. An edge whose count lands after the close cycle is credited to the next window.
- **Window period:** with `en` held high, `valid` pulses every `GATE_CYCLES` cycles. The first pulse occurs `GATE_CYCLES` cycles after the enabling cycle.
- **Output stability:** `freq_hz` and `overflow` change only in the close cycle or on reset, and are stable for a full window.

## Test plan

Use `GATE_CYCLES` = 1000 and `CNT_W` = 16 unless noted.

1. `sig_in` period of 10 clk (5 high / 5 low), `en` = 1 for 3 windows → `valid` pulses every 1000 cycles, and each pulse shows `freq_hz` = 100 and `overflow` = 0.
2. `sig_in` held at 0, `en` = 1 → `freq_hz` = 0 on every `valid` pulse.
3. `CNT_W` = 6, `sig_in` period of 10 clk → `freq_hz` = 63 and `overflow` = 1. Then switch to a 40-clk period → the next full window shows `freq_hz` = 25 and `overflow` = 0.
4. First window measured at 100; `en` dropped at cycle 500 of the second window for 300 cycles, then raised → no `valid` during the gap, and `freq_hz` holds 100. The next `valid` arrives 1000 cycles after `en` rises.
5. `rst_n` pulsed low at cycle 700 of a window after `freq_hz` = 100 → outputs go to 0 immediately. The first `valid` comes 1000 cycles after restart.
6. Single `sig_in` rise timed so `edge_det` coincides with the close cycle, with no other edges → `freq_hz` = 1 in that window and 0 in the next.
